// File: rtl/hilo_muldiv_controller.sv
// hilo_muldiv_controller: sequences every HI/LO write (multiply, restoring divide, MTHI/MTLO).
// Define HILO_MADD_EN to implement MADD/MADDU/MSUB/MSUBU; otherwise opcodes 7-10 act as NOP.
module hilo_muldiv_controller #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [3:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [63:0] HiLoReg,
   input  logic        ReadRequest,
   output logic        Busy,
   output logic        Stall,
   output logic        WriteEnable,
   output logic [63:0] WriteData,
   output logic        DivByZero
);
   localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
   localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB = 4'd9, OP_MSUBU = 4'd10;
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WRITE} state_t;
   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        accept, in_div, in_mov, div_q, sdiv_q, msigned, ge;
   logic [32:0] shl;
   logic [31:0] sub;
   logic [63:0] ax, bx, prod, acc, wdata;
`ifdef HILO_MADD_EN
   assign accept = Start && state_q == IDLE && Op inside {[OP_MULT:OP_MSUBU]};
   assign acc = (op_q == OP_MADD || op_q == OP_MADDU) ? HiLoReg + prod
              : (op_q == OP_MSUB || op_q == OP_MSUBU) ? HiLoReg - prod : prod;
`else
   assign accept = Start && state_q == IDLE && Op inside {[OP_MULT:OP_MTLO]};
   assign acc = prod;
`endif
   assign in_div  = Op == OP_DIV || Op == OP_DIVU;
   assign in_mov  = Op == OP_MTHI || Op == OP_MTLO;
   assign div_q   = op_q == OP_DIV || op_q == OP_DIVU;
   assign sdiv_q  = op_q == OP_DIV;
   assign msigned = op_q == OP_MULT || op_q == OP_MADD || op_q == OP_MSUB;
   assign ax      = {{32{msigned & a_q[31]}}, a_q};
   assign bx      = {{32{msigned & b_q[31]}}, b_q};
   assign prod    = ax * bx;
   // One restoring step: the partial remainder always stays below the divisor, so 32 bits hold it
   assign shl     = {rem_q, quo_q[31]};
   assign ge      = shl >= {1'b0, dvs_q};
   assign sub     = shl[31:0] - dvs_q;
   assign wdata   = op_q == OP_MTHI ? {a_q, HiLoReg[31:0]}
                  : op_q == OP_MTLO ? {HiLoReg[63:32], a_q}
                  : div_q ? {rem_q, quo_q} : acc;
   assign Busy        = state_q != IDLE;
   assign Stall       = ReadRequest && Busy;
   assign WriteEnable = state_q == WRITE;
   assign WriteData   = WriteEnable ? wdata : 64'd0;
   assign DivByZero   = WriteEnable && div_q && b_q == 32'd0;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      unique case (state_q)
         IDLE: if (accept) begin
            op_d    = Op;
            a_d     = A;
            b_d     = B;
            rem_d   = 32'd0;
            quo_d   = (Op == OP_DIV && A[31]) ? -A : A;
            dvs_d   = (Op == OP_DIV && B[31]) ? -B : B;
            cnt_d   = in_div ? 5'd31 : 5'(MUL_CYCLES - 2);
            state_d = in_mov ? WRITE : in_div ? DIV : MUL_CYCLES == 1 ? WRITE : MUL;
         end
         MUL: begin
            cnt_d   = cnt_q - 5'd1;
            state_d = cnt_q == 5'd0 ? WRITE : MUL;
         end
         DIV: begin
            rem_d   = ge ? sub : shl[31:0];
            quo_d   = {quo_q[30:0], ge};
            cnt_d   = cnt_q - 5'd1;
            state_d = cnt_q == 5'd0 ? FIX : DIV;
         end
         FIX: begin
            // Divide by zero still ran its iterations; the result is forced here
            rem_d   = b_q == 32'd0 ? a_q : (sdiv_q && a_q[31]) ? -rem_q : rem_q;
            quo_d   = b_q == 32'd0 ? 32'hFFFF_FFFF : (sdiv_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
            state_d = WRITE;
         end
         WRITE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         cnt_q   <= 5'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         dvs_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// tb_hilo_muldiv_controller: vector table plus corner sequences for the HI/LO sequencer.
// Expected writes go into a scoreboard queue at issue time and are checked when WriteEnable fires.
module tb_hilo_muldiv_controller;
   localparam int MC = 2;
`ifdef HILO_MADD_EN
   localparam int ML = MC;
`else
   localparam int ML = 0;
`endif
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] hilo;
      logic [63:0] exp;
      logic        dbz;
      int          lat;
   } vec_t;
   typedef struct {
      logic [63:0] d;
      logic        z;
      int          at;
   } exp_t;
   logic        clk = 0, Reset = 1, Start = 0, ReadRequest = 0;
   logic [3:0]  Op = 0;
   logic [31:0] A = 0, B = 0;
   logic [63:0] HiLoReg = 0;
   logic        Busy, Stall, WriteEnable, DivByZero;
   logic [63:0] WriteData;
   int          total = 0, bad = 0, cyc = 0;
   exp_t        sbq[$];
   vec_t        tbl[14];

   hilo_muldiv_controller #(.MUL_CYCLES(MC)) dut (
      .Clock(clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiLoReg(HiLoReg), .ReadRequest(ReadRequest), .Busy(Busy), .Stall(Stall),
      .WriteEnable(WriteEnable), .WriteData(WriteData), .DivByZero(DivByZero)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      if (WriteEnable) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got %h want no write (cycle %0d)", WriteData, cyc);
         end else begin
            e = sbq.pop_front();
            check("wdata", WriteData, e.d);
            check("dbz", {63'd0, DivByZero}, {63'd0, e.z});
            check("write_cycle", 64'(cyc), 64'(e.at));
         end
      end else begin
         check("wdata_idle_zero", WriteData, 64'd0);
         check("dbz_idle_low", {63'd0, DivByZero}, 64'd0);
      end
   end

   task automatic run(input vec_t v, input int intr_k, input logic rr);
      exp_t e;
      @(negedge clk);
      Start = 1; Op = v.op; A = v.a; B = v.b; HiLoReg = v.hilo; ReadRequest = rr;
      if (v.lat > 0) begin
         e.d = v.exp; e.z = v.dbz; e.at = cyc + v.lat;
         sbq.push_back(e);
      end
      for (int k = 1; k <= v.lat; k++) begin
         @(negedge clk);
         Start = (k == intr_k);
         if (k == intr_k) Op = 4'd6;
         check("busy", {63'd0, Busy}, 64'd1);
         check("stall", {63'd0, Stall}, {63'd0, rr});
      end
      @(negedge clk);
      Start = 0;
      check("busy_done", {63'd0, Busy}, 64'd0);
      check("stall_done", {63'd0, Stall}, 64'd0);
      ReadRequest = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      tbl[0]  = '{4'd1,  32'hFFFF_FFFE, 32'd3,        64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, MC};
      tbl[1]  = '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, MC};
      tbl[2]  = '{4'd1,  32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 1'b0, MC};
      tbl[3]  = '{4'd3,  32'hFFFF_FFF9, 32'd2,        64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34};
      tbl[4]  = '{4'd4,  32'd7,         32'd0,        64'd0, 64'h0000_0007_FFFF_FFFF, 1'b1, 34};
      tbl[5]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 34};
      tbl[6]  = '{4'd4,  32'd100,       32'd7,        64'd0, 64'h0000_0002_0000_000E, 1'b0, 34};
      tbl[7]  = '{4'd3,  32'd7,         32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD, 1'b0, 34};
      tbl[8]  = '{4'd5,  32'h1234_5678, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB, 64'h1234_5678_BBBB_BBBB, 1'b0, 1};
      tbl[9]  = '{4'd6,  32'h8765_4321, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB, 64'hAAAA_AAAA_8765_4321, 1'b0, 1};
      tbl[10] = '{4'd0,  32'd5,         32'd6,        64'd0, 64'd0, 1'b0, 0};
      tbl[11] = '{4'd13, 32'd5,         32'd6,        64'd0, 64'd0, 1'b0, 0};
      tbl[12] = '{4'd10, 32'd1,         32'd1,        64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ML};
      tbl[13] = '{4'd3,  32'h8000_0000, 32'd0,        64'd0, 64'h8000_0000_FFFF_FFFF, 1'b1, 34};
      ReadRequest = 1;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, Busy}, 64'd0);
      check("rst_stall", {63'd0, Stall}, 64'd0);
      check("rst_we", {63'd0, WriteEnable}, 64'd0);
      check("rst_wdata", WriteData, 64'd0);
      Reset = 0; ReadRequest = 0;
      foreach (tbl[i]) run(tbl[i], 0, 1'b0);
`ifdef HILO_MADD_EN
      run('{4'd7, 32'hFFFF_FFFF, 32'd2, 64'd5, 64'd3, 1'b0, MC}, 0, 1'b0);
      run('{4'd8, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFE, 1'b0, MC}, 0, 1'b0);
`endif
      // DIV in flight: an MTLO pulsed at t0+5 must be dropped while reads stall
      run('{4'd3, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34}, 5, 1'b1);
      // Reset in the middle of a DIV abandons it without a write
      @(negedge clk);
      Start = 1; Op = 4'd3; A = 32'd100; B = 32'd3;
      @(negedge clk);
      Start = 0;
      repeat (9) @(negedge clk);
      check("busy_pre_reset", {63'd0, Busy}, 64'd1);
      Reset = 1;
      @(negedge clk);
      Reset = 0;
      check("busy_post_reset", {63'd0, Busy}, 64'd0);
      check("we_post_reset", {63'd0, WriteEnable}, 64'd0);
      check("wdata_post_reset", WriteData, 64'd0);
      v = '{4'd1, 32'd3, 32'd4, 64'd0, 64'd12, 1'b0, MC};
      run(v, 0, 1'b0);
      repeat (2) @(negedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
